// File: rtl/axi_lite_pkg.sv
// Shared encodings and helpers for the AXI4-Lite register file.
// Latency: none, declarations only.
// Backpressure: not applicable.
package axi_lite_pkg;

    localparam logic [1:0] S_WRIDLE  = 2'd0;
    localparam logic [1:0] S_WRWAITD = 2'd1;
    localparam logic [1:0] S_WRWAITA = 2'd2;
    localparam logic [1:0] S_WRRESP  = 2'd3;

    localparam logic S_RDIDLE = 1'b0;
    localparam logic S_RDDATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle; the instance name supplies the s_axi_ prefix.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface axi_lite_regfile_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input  bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input  rready
    );

    modport master (
        output awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid, input  wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input  arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/axi_lite_wr_ctrl.sv
// Write-channel FSM: accepts AW and W in any order, emits one commit strobe per write.
// Latency: commit is asserted in the cycle of the final AW/W handshake; bvalid follows one cycle later.
// Backpressure: AW/W stall while a response is outstanding; bvalid holds until bready.
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [IDX_W-1:0] aw_idx,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wvalid,
    output logic             wready,
    output logic             bvalid,
    input  logic             bready,
    output logic             commit,
    output logic [IDX_W-1:0] commit_idx,
    output logic [31:0]      commit_data,
    output logic [31:0]      commit_mask
);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      data_q;
    logic [3:0]       strb_q;
    logic             aw_hs;
    logic             w_hs;

    // Readies come from state only, so no valid-to-ready path exists.
    assign awready = !areset && (state == S_WRIDLE || state == S_WRWAITA);
    assign wready  = !areset && (state == S_WRIDLE || state == S_WRWAITD);
    assign bvalid  = (state == S_WRRESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        commit = 1'b0;
        case (state)
            S_WRIDLE:  commit = aw_hs && w_hs;
            S_WRWAITD: commit = w_hs;
            S_WRWAITA: commit = aw_hs;
            default:   commit = 1'b0;
        endcase
        commit_idx  = aw_hs ? aw_idx : idx_q;
        commit_data = w_hs ? wdata : data_q;
        commit_mask = strb_mask(w_hs ? wstrb : strb_q);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= S_WRIDLE;
            idx_q  <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else begin
            case (state)
                S_WRIDLE: begin
                    if (aw_hs && w_hs) begin
                        state <= S_WRRESP;
                    end else if (aw_hs) begin
                        idx_q <= aw_idx;
                        state <= S_WRWAITD;
                    end else if (w_hs) begin
                        data_q <= wdata;
                        strb_q <= wstrb;
                        state  <= S_WRWAITA;
                    end
                end
                S_WRWAITD: if (w_hs)   state <= S_WRRESP;
                S_WRWAITA: if (aw_hs)  state <= S_WRRESP;
                default:   if (bready) state <= S_WRIDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file with read-only status slots and per-register strobes; AXIL_SLVERR_EN enables SLVERR responses.
// Latency: bvalid/reg_out/wr_pulse one cycle after the last write handshake; rvalid/rd_pulse one cycle after AR.
// Backpressure: each channel holds its response until bready/rready and accepts nothing new meanwhile.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    C_NUM_REGS  = 8,
    parameter int                    C_ADDR_BITS = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK   = '0
) (
    input  logic                      aclk,
    input  logic                      areset,
    axi_lite_regfile_if.slave         s_axi,
    output logic [32*C_NUM_REGS-1:0]  reg_out,
    input  logic [32*C_NUM_REGS-1:0]  reg_in,
    output logic [C_NUM_REGS-1:0]     wr_pulse,
    output logic [C_NUM_REGS-1:0]     rd_pulse
);

    localparam int IDX_W = C_ADDR_BITS - 2;

    logic [31:0]      regs [C_NUM_REGS];
    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_data;
    logic [31:0]      commit_mask;
    logic             wr_hit;
    logic             wr_ro;
    logic             wr_ok;
    logic [1:0]       wr_resp;
    logic [1:0]       bresp_q;

    logic             rd_state;
    logic             ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_val;
    logic             rd_hit;
    logic             rd_ro;
    logic [C_NUM_REGS-1:0] rd_onehot;
    logic [1:0]       rd_resp;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, s_axi.awaddr[31:C_ADDR_BITS], s_axi.awaddr[1:0],
                                s_axi.araddr[31:C_ADDR_BITS], s_axi.araddr[1:0]};

    axi_lite_wr_ctrl #(.IDX_W(IDX_W)) u_wr_ctrl (
        .aclk        (aclk),
        .areset      (areset),
        .aw_idx      (s_axi.awaddr[C_ADDR_BITS-1:2]),
        .awvalid     (s_axi.awvalid),
        .awready     (s_axi.awready),
        .wdata       (s_axi.wdata),
        .wstrb       (s_axi.wstrb),
        .wvalid      (s_axi.wvalid),
        .wready      (s_axi.wready),
        .bvalid      (s_axi.bvalid),
        .bready      (s_axi.bready),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_mask (commit_mask)
    );

    always_comb begin
        wr_hit = 1'b0;
        wr_ro  = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (commit_idx == IDX_W'(i)) begin
                wr_hit = 1'b1;
                wr_ro  = C_RO_MASK[i];
            end
        end
    end

    assign wr_ok = wr_hit && !wr_ro;

`ifdef AXIL_SLVERR_EN
    assign wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (rd_hit && !rd_ro) || (rd_hit && rd_ro) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                bresp_q <= wr_resp;
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (wr_ok && commit_idx == IDX_W'(i)) begin
                        regs[i]     <= (commit_data & commit_mask) | (regs[i] & ~commit_mask);
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign s_axi.bresp = bresp_q;

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = C_RO_MASK[g] ? 32'h0 : regs[g];
    end

    assign s_axi.arready = !areset && (rd_state == S_RDIDLE);
    assign s_axi.rvalid  = (rd_state == S_RDDATA);
    assign ar_hs         = s_axi.arvalid && s_axi.arready;
    assign ar_idx        = s_axi.araddr[C_ADDR_BITS-1:2];

    // Reads sample the array before any same-edge commit lands.
    always_comb begin
        rd_val    = '0;
        rd_hit    = 1'b0;
        rd_ro     = 1'b0;
        rd_onehot = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_hit       = 1'b1;
                rd_ro        = C_RO_MASK[i];
                rd_onehot[i] = 1'b1;
                rd_val       = C_RO_MASK[i] ? reg_in[32*i +: 32] : regs[i];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state <= S_RDIDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rd_pulse <= '0;
        end else begin
            rd_pulse <= '0;
            if (rd_state == S_RDIDLE) begin
                if (ar_hs) begin
                    rdata_q  <= rd_val;
                    rresp_q  <= rd_resp;
                    rd_pulse <= rd_onehot;
                    rd_state <= S_RDDATA;
                end
            end else if (s_axi.rready) begin
                rd_state <= S_RDIDLE;
            end
        end
    end

    assign s_axi.rdata = rdata_q;
    assign s_axi.rresp = rresp_q;

endmodule
